fetch_bus_sequencer: RTL and testbench
======================================

# fetch_bus_sequencer

Owns the core's single 8-bit memory bus. It shares the bus between instruction prefetch and execute-stage data accesses, and fills the 16-byte instruction prefetch queue that feeds the prime decoder. It also flushes and redirects the queue when a branch or jump is taken. It sits between inst_fetch/branch (redirects), the execute stage (data requests) and external memory.

## Interface
- ADDR_W, 16, address width
- QDEPTH, 16, prefetch queue depth in bytes; power of 2, ≥4
- RESET_PC, 16'h0000, first prefetch address after reset
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  ADDR_W  new fetch address
- data_req  in  1  execute-stage access request; held until data_ack
- data_we  in  1  1 = write
- data_addr  in  ADDR_W  data address
- data_wdata  in  8  write data
- data_ack  out  1  access done (combinational, = mem_ack in D_BUSY)
- data_rdata  out  8  read data, valid with data_ack
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write enable, registered
- mem_addr  out  ADDR_W  bus address, registered
- mem_wdata  out  8  bus write data, registered
- mem_ack  in  1  one-cycle completion strobe, variable latency ≥1
- mem_rdata  in  8  read data, valid with mem_ack
- q_pop_len  in  2  bytes consumed by decoder this cycle (0–3)
- q_count  out  log2(QDEPTH)+1  bytes held in queue
- q_data0, q_data1, q_data2  out  8 each  queue head bytes 0..2
- fetch_pc  out  ADDR_W  address of next byte to prefetch
- q_underflow  out  1  one-cycle pulse on illegal pop

## Operation
- FSM states: IDLE, IF_BUSY (instruction read outstanding), D_BUSY (data access outstanding), IF_DROP (instruction read outstanding, result to be discarded).
- At most one bus access is outstanding at a time.
- mem_req, mem_addr, mem_we and mem_wdata stay stable from issue until the mem_ack cycle. mem_req is low the cycle after mem_ack.
- IDLE arbitration, priority order:
  - data_req: go to D_BUSY, drive data_addr/we/wdata.
  - Otherwise, if q_count < QDEPTH: go to IF_BUSY, mem_addr = fetch_pc, mem_we = 0.
  - Otherwise stay in IDLE.
- Slot reservation: the fetch is issued only while q_count < QDEPTH. Pops only free space, so a returning byte always fits.
- IF_BUSY + mem_ack, no redirect: push mem_rdata at tail; fetch_pc += 1 (wraps FFFF→0000); go to IDLE.
- D_BUSY + mem_ack: data_ack = 1 and data_rdata = mem_rdata in that cycle; go to IDLE. No queue push, fetch_pc unchanged.
- redirect_valid (any state), applied in the same cycle:
  - Queue is emptied (q_count → 0) and fetch_pc ← redirect_pc.
  - It overrides a same-cycle pop and a same-cycle push.
  - In IF_BUSY without mem_ack: go to IF_DROP.
  - In IF_BUSY with mem_ack: the returning byte is discarded; go to IDLE.
  - In D_BUSY: the data access continues unaffected.
  - In IF_DROP: fetch_pc is updated again; stay in IF_DROP.
- IF_DROP + mem_ack: discard mem_rdata; go to IDLE.
- Pop:
  - q_pop_len ≤ q_count: head advances by q_pop_len.
  - q_pop_len > q_count: pop ignored entirely, q_underflow pulses.
  - A simultaneous push and pop is legal: q_count ← q_count + 1 − q_pop_len. The count check uses pre-push q_count.
- q_dataN = byte at head+N if N < q_count, else 8'h00. Queue pointers wrap modulo QDEPTH.
- mem_ack in IDLE is ignored.

## Timing
- Request to mem_req: 1 cycle. data_req seen high in IDLE at cycle T gives mem_req high at T+1.
- mem_ack at cycle N:
  - data_ack at N (combinational).
  - Pushed byte visible in q_count/q_dataN at N+1.
  - Next access can assert mem_req at N+2 at the earliest.
- Redirect at cycle R: q_count = 0 and fetch_pc = redirect_pc at R+1.
  - In IDLE, the first fetch at redirect_pc can assert mem_req at R+2.
  - From IF_BUSY/IF_DROP, it waits for the pending mem_ack.
- Requester must drop data_req or present a new request in the cycle after data_ack.
- Reset (asynchronous, mid-access allowed):
  - state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, q_count = 0, head/tail = 0, q_dataN = 0, fetch_pc = RESET_PC, q_underflow = 0.
  - data_ack = 0 and data_rdata = 0 (combinational outputs are 0 outside D_BUSY).
  - The abandoned access's later mem_ack is ignored.

## Test plan
- Cold fill: reset, mem_ack latency 1, no pops → reads at 0000..000F, q_count = 16, then mem_req stays 0. Pop 3 → next fetch at 0010.
- Data priority: queue not full, data_req read at 1234 in IDLE → mem_addr = 1234, mem_we = 0. mem_ack with rdata = A5 → data_ack = 1, data_rdata = A5, q_count unchanged.
- Redirect during IF_BUSY: fetch of 0005 outstanding, redirect to 8000 → q_count = 0 next cycle. Byte returned for 0005 is discarded; next mem_addr = 8000.
- Redirect coincident with mem_ack and pop_len = 2 → q_count = 0, fetch_pc = redirect_pc, no push, no q_underflow.
- Underflow: q_count = 1, q_pop_len = 3 → q_underflow pulses, q_count stays 1. Concurrent push with pop_len = 1 at q_count = 1 → q_count = 1.
- Wrap and reset: redirect to FFFF, one fetch → fetch_pc = 0000. Assert rst_n low while in D_BUSY → mem_req = 0 immediately, fetch_pc = RESET_PC; a late mem_ack is ignored.

Source files
------------

// File: rtl/fetch_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_bus_sequencer
//  Purpose  : Arbitrates the single 8-bit memory bus between data accesses and
//             instruction prefetch, and maintains the prefetch byte queue.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_bus_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter int                QDEPTH   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     data_req,
  input  logic                     data_we,
  input  logic [ADDR_W-1:0]        data_addr,
  input  logic [7:0]               data_wdata,
  output logic                     data_ack,
  output logic [7:0]               data_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  input  logic [1:0]               q_pop_len,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic [7:0]               q_data0,
  output logic [7:0]               q_data1,
  output logic [7:0]               q_data2,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic                     q_underflow
);

  localparam int c_ptr_w = $clog2(QDEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_if_busy = 2'd1;
  localparam logic [1:0] c_st_d_busy  = 2'd2;
  localparam logic [1:0] c_st_if_drop = 2'd3;

  logic [1:0]         r_state;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_mem_wdata;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic               r_underflow;
  logic [7:0]         r_q [QDEPTH];

  logic               w_push;
  logic               w_pop_ok;
  logic [1:0]         w_pop_amt;
  logic               w_underflow;
  logic               w_has_room;
  logic [7:0]         w_head_byte [3];

  // Only a non-redirected instruction return lands in the queue.
  assign w_push      = (r_state == c_st_if_busy) && mem_ack && !redirect_valid;
  assign w_pop_ok    = c_cnt_w'(q_pop_len) <= r_count;
  assign w_pop_amt   = w_pop_ok ? q_pop_len : 2'd0;
  assign w_underflow = !redirect_valid && !w_pop_ok;
  assign w_has_room  = r_count < c_cnt_w'(QDEPTH);

  assign data_ack   = (r_state == c_st_d_busy) && mem_ack;
  assign data_rdata = data_ack ? mem_rdata : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_underflow;
      case (r_state)
        c_st_idle: begin
          if (data_req) begin
            r_state     <= c_st_d_busy;
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_we;
            r_mem_addr  <= data_addr;
            r_mem_wdata <= data_wdata;
          end else if (!redirect_valid && w_has_room) begin
            // A redirect this cycle would make r_fetch_pc stale; fetch next cycle.
            r_state    <= c_st_if_busy;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_fetch_pc;
          end
        end
        c_st_if_busy: begin
          if (mem_ack) begin
            r_state   <= c_st_idle;
            r_mem_req <= 1'b0;
          end else if (redirect_valid) begin
            r_state <= c_st_if_drop;
          end
        end
        c_st_d_busy, c_st_if_drop: begin
          if (mem_ack) begin
            r_state   <= c_st_idle;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state   <= c_st_idle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc;
    end else begin
      r_head  <= r_head + c_ptr_w'(w_pop_amt);
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop_amt);
      if (w_push) begin
        r_tail     <= r_tail + c_ptr_w'(1);
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  // Storage needs no reset: bytes beyond q_count are masked on output.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_tail] <= mem_rdata;
    end
  end

  for (genvar n = 0; n < 3; n++) begin : g_head_bytes
    logic [c_ptr_w-1:0] w_idx;
    assign w_idx          = r_head + c_ptr_w'(n);
    assign w_head_byte[n] = (c_cnt_w'(n) < r_count) ? r_q[w_idx] : 8'h00;
  end

  assign q_data0     = w_head_byte[0];
  assign q_data1     = w_head_byte[1];
  assign q_data2     = w_head_byte[2];
  assign q_count     = r_count;
  assign fetch_pc    = r_fetch_pc;
  assign q_underflow = r_underflow;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fetch_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_bus_sequencer
//  Purpose  : Directed vector table plus hand-written corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_ack;
  logic [7:0]  data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [1:0]  q_pop_len;
  logic [4:0]  q_count;
  logic [7:0]  q_data0, q_data1, q_data2;
  logic [15:0] fetch_pc;
  logic        q_underflow;

  int n_total = 0;
  int n_pass  = 0;

  fetch_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .q_pop_len(q_pop_len), .q_count(q_count),
    .q_data0(q_data0), .q_data1(q_data1), .q_data2(q_data2),
    .fetch_pc(fetch_pc), .q_underflow(q_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [15:0] rpc;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic        ack;
    logic [7:0]  rd;
    logic [1:0]  pop;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic [4:0]  e_cnt;
    logic [15:0] e_pc;
    logic [7:0]  e_d0;
    logic [7:0]  e_d1;
    logic        e_dack;
    logic [7:0]  e_drd;
    logic        e_uf;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    data_req = 1'b0; data_we = 1'b0; data_addr = 16'h0000; data_wdata = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00; q_pop_len = 2'd0;
  endtask

  // Bounded wait for mem_req, sampled on falling edges.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    //        redir rpc       dreq dwe daddr     dwd    ack rd     pop   e_req e_addr    e_we e_wd   e_cnt  e_pc      e_d0   e_d1   dack drd    uf
    vecs[0]  = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd0, 16'h0000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[1]  = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00,2'd0, 1'b1,16'h1234,1'b0,8'h00,5'd0, 16'h0000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[2]  = '{1'b0,16'h0000,1'b1,1'b0,16'h1234,8'h00,1'b1,8'hA5,2'd0, 1'b1,16'h1234,1'b0,8'h00,5'd0, 16'h0000,8'h00,8'h00,1'b1,8'hA5,1'b0};
    vecs[3]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd0, 16'h0000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[4]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h11,2'd0, 1'b1,16'h0000,1'b0,8'h00,5'd0, 16'h0000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[5]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h0001,8'h11,8'h00,1'b0,8'h00,1'b0};
    vecs[6]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd3, 1'b1,16'h0001,1'b0,8'h00,5'd1, 16'h0001,8'h11,8'h00,1'b0,8'h00,1'b0};
    vecs[7]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h22,2'd1, 1'b1,16'h0001,1'b0,8'h00,5'd1, 16'h0001,8'h11,8'h00,1'b0,8'h00,1'b1};
    vecs[8]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h0002,8'h22,8'h00,1'b0,8'h00,1'b0};
    vecs[9]  = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b1,16'h0002,1'b0,8'h00,5'd1, 16'h0002,8'h22,8'h00,1'b0,8'h00,1'b0};
    vecs[10] = '{1'b1,16'h8000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b1,16'h0002,1'b0,8'h00,5'd1, 16'h0002,8'h22,8'h00,1'b0,8'h00,1'b0};
    vecs[11] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h33,2'd0, 1'b1,16'h0002,1'b0,8'h00,5'd0, 16'h8000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[12] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd0, 16'h8000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[13] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h44,2'd0, 1'b1,16'h8000,1'b0,8'h00,5'd0, 16'h8000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[14] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h8001,8'h44,8'h00,1'b0,8'h00,1'b0};
    vecs[15] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h55,2'd0, 1'b1,16'h8001,1'b0,8'h00,5'd1, 16'h8001,8'h44,8'h00,1'b0,8'h00,1'b0};
    vecs[16] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd2, 16'h8002,8'h44,8'h55,1'b0,8'h00,1'b0};
    vecs[17] = '{1'b1,16'hFFFF,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h66,2'd2, 1'b1,16'h8002,1'b0,8'h00,5'd2, 16'h8002,8'h44,8'h55,1'b0,8'h00,1'b0};
    vecs[18] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd0, 16'hFFFF,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[19] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h77,2'd0, 1'b1,16'hFFFF,1'b0,8'h00,5'd0, 16'hFFFF,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[20] = '{1'b1,16'h1000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h0000,8'h77,8'h00,1'b0,8'h00,1'b0};
    vecs[21] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd0, 16'h1000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[22] = '{1'b0,16'h0000,1'b1,1'b1,16'h4321,8'h9C,1'b1,8'h88,2'd0, 1'b1,16'h1000,1'b0,8'h00,5'd0, 16'h1000,8'h00,8'h00,1'b0,8'h00,1'b0};
    vecs[23] = '{1'b0,16'h0000,1'b1,1'b1,16'h4321,8'h9C,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h1001,8'h88,8'h00,1'b0,8'h00,1'b0};
    vecs[24] = '{1'b0,16'h0000,1'b1,1'b1,16'h4321,8'h9C,1'b1,8'h5E,2'd0, 1'b1,16'h4321,1'b1,8'h9C,5'd1, 16'h1001,8'h88,8'h00,1'b1,8'h5E,1'b0};
    vecs[25] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00,2'd0, 1'b0,16'h0000,1'b0,8'h00,5'd1, 16'h1001,8'h88,8'h00,1'b0,8'h00,1'b0};

    clear_inputs();
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    chk("rst_q_count",  {27'd0, q_count}, 32'd0);
    chk("rst_fetch_pc", {16'd0, fetch_pc}, 32'h0);
    chk("rst_q_data0",  {24'd0, q_data0}, 32'h0);
    chk("rst_underflow",{31'd0, q_underflow}, 32'd0);
    chk("rst_data_ack", {31'd0, data_ack}, 32'd0);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      data_req = vecs[i].dreq; data_we = vecs[i].dwe;
      data_addr = vecs[i].daddr; data_wdata = vecs[i].dwd;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rd; q_pop_len = vecs[i].pop;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
        if (vecs[i].e_we)
          chk($sformatf("v%0d_mem_wdata", i), {24'd0, mem_wdata}, {24'd0, vecs[i].e_wd});
      end
      chk($sformatf("v%0d_q_count", i), {27'd0, q_count}, {27'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_fetch_pc", i), {16'd0, fetch_pc}, {16'd0, vecs[i].e_pc});
      chk($sformatf("v%0d_q_data0", i), {24'd0, q_data0}, {24'd0, vecs[i].e_d0});
      chk($sformatf("v%0d_q_data1", i), {24'd0, q_data1}, {24'd0, vecs[i].e_d1});
      chk($sformatf("v%0d_data_ack", i), {31'd0, data_ack}, {31'd0, vecs[i].e_dack});
      chk($sformatf("v%0d_data_rdata", i), {24'd0, data_rdata}, {24'd0, vecs[i].e_drd});
      chk($sformatf("v%0d_underflow", i), {31'd0, q_underflow}, {31'd0, vecs[i].e_uf});
      @(posedge clk); #1;
    end
    clear_inputs();

    // Cold fill with a single-cycle-latency memory.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_req($sformatf("fill%0d_req", i));
      chk($sformatf("fill%0d_addr", i), {16'd0, mem_addr}, i);
      mem_ack   = 1'b1;
      mem_rdata = 8'(8'hA0 + i);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("full%0d_no_req", i), {31'd0, mem_req}, 32'd0);
    end
    chk("full_q_count", {27'd0, q_count}, 32'd16);
    chk("full_q_data0", {24'd0, q_data0}, 32'hA0);
    chk("full_q_data1", {24'd0, q_data1}, 32'hA1);
    chk("full_q_data2", {24'd0, q_data2}, 32'hA2);
    chk("full_fetch_pc", {16'd0, fetch_pc}, 32'h0010);
    @(posedge clk); #1;
    q_pop_len = 2'd3;
    @(posedge clk); #1;
    q_pop_len = 2'd0;
    @(negedge clk);
    chk("pop3_q_count", {27'd0, q_count}, 32'd13);
    chk("pop3_q_data0", {24'd0, q_data0}, 32'hA3);
    chk("pop3_q_data2", {24'd0, q_data2}, 32'hA5);
    wait_req("refill_req");
    chk("refill_addr", {16'd0, mem_addr}, 32'h0010);
    chk("refill_we", {31'd0, mem_we}, 32'd0);

    // Asynchronous reset in the middle of a data access.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    data_req  = 1'b1;
    data_addr = 16'h0BEE;
    @(negedge clk);
    chk("dreq_req_lat0", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dreq_req_lat1", {31'd0, mem_req}, 32'd1);
    chk("dreq_addr", {16'd0, mem_addr}, 32'h0BEE);
    #1;
    rst_n     = 1'b0;
    data_req  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'hC3;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_data_ack", {31'd0, data_ack}, 32'd0);
    chk("arst_data_rdata", {24'd0, data_rdata}, 32'h0);
    chk("arst_fetch_pc", {16'd0, fetch_pc}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_data_ack", {31'd0, data_ack}, 32'd0);
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_q_count", {27'd0, q_count}, 32'd0);
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", {16'd0, mem_addr}, 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
